// File: rtl/accumulator_array.sv
// accumulator_array
//   Double-buffered row accumulator placed between the systolic MMU and the
//   activation pipeline. Staggered MMU column results are de-skewed into
//   aligned rows. Each row is then added to, or written over, one row slot of
//   the selected buffer. Every updated row is queued in an output FIFO with a
//   valid/ready handshake.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-high reset, clears all state and memory
//   clear      : synchronous flush of in-flight rows, FIFO, slot pointers, flags
//   valid_in   : column 0 of a new row is on mmu_in this cycle
//   acc_mode   : 1 = add to slot, 0 = overwrite slot (sampled with valid_in)
//   buf_sel    : target buffer (sampled with valid_in)
//   mmu_in     : COLS signed IN_W results, column c at [c*IN_W +: IN_W]
//   out_ready  : consumer accepts the FIFO head
//   out_valid  : FIFO non-empty
//   out_data   : post-update row, column c at [c*ACC_W +: ACC_W]
//   out_buf    : buffer of the head entry
//   out_row    : slot index of the head entry
//   sat_flag   : sticky overflow indication (clamp or wrap)
//   drop_flag  : sticky indication that a row was lost to a full FIFO
module accumulator_array #(
  parameter int COLS      = 4,
  parameter int IN_W      = 16,
  parameter int ACC_W     = 32,
  parameter int DEPTH     = 4,
  parameter int OUT_DEPTH = 4,
  parameter int SATURATE  = 1,
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  valid_in,
  input  logic                  acc_mode,
  input  logic                  buf_sel,
  input  logic [COLS*IN_W-1:0]  mmu_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [COLS*ACC_W-1:0] out_data,
  output logic                  out_buf,
  output logic [RW-1:0]         out_row,
  output logic                  sat_flag,
  output logic                  drop_flag
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // De-skew. Column c arrives c cycles after column 0, so it passes through
  // COLS-c registers. All columns of a row land in the last stage together,
  // COLS-1 edges after valid_in was sampled.
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0] aligned [COLS];

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    localparam int N = COLS - gi;
    logic [IN_W-1:0] dl_q [N];
    logic [IN_W-1:0] dl_d [N];

    always_comb begin
      dl_d[0] = mmu_in[gi*IN_W +: IN_W];
      for (int j = 1; j < N; j++) dl_d[j] = dl_q[j-1];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int j = 0; j < N; j++) dl_q[j] <= '0;
      end else begin
        dl_q <= dl_d;
      end
    end

    assign aligned[gi] = dl_q[N-1];
  end

  // Row control travels alongside column 0 through the same number of stages.
  logic [COLS-1:0] vld_q, vld_d;
  logic [COLS-1:0] mode_q, mode_d;
  logic [COLS-1:0] bsel_q, bsel_d;

  always_comb begin
    vld_d  = '0;
    mode_d = '0;
    bsel_d = '0;
    vld_d[0]  = valid_in;
    mode_d[0] = acc_mode;
    bsel_d[0] = buf_sel;
    for (int i = 1; i < COLS; i++) begin
      vld_d[i]  = vld_q[i-1];
      mode_d[i] = mode_q[i-1];
      bsel_d[i] = bsel_q[i-1];
    end
    // Flushing only the valid bits is enough to discard every in-flight row.
    if (clear) vld_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      mode_q <= '0;
      bsel_q <= '0;
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      bsel_q <= bsel_d;
    end
  end

  logic row_vld, row_mode, row_buf, wr_en;
  assign row_vld  = vld_q[COLS-1];
  assign row_mode = mode_q[COLS-1];
  assign row_buf  = bsel_q[COLS-1];
  // A clear on the commit edge also discards the row that would be written.
  assign wr_en    = row_vld && !clear;

  // ---------------------------------------------------------------------------
  // Slot pointers, one per buffer.
  // ---------------------------------------------------------------------------
  logic [RW-1:0] ptr_q [2];
  logic [RW-1:0] ptr_d [2];
  logic [RW-1:0] slot_ptr;

  assign slot_ptr = ptr_q[row_buf];

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d[0] = '0;
      ptr_d[1] = '0;
    end else if (row_vld) begin
      ptr_d[row_buf] = (slot_ptr == RW'(DEPTH - 1)) ? '0 : slot_ptr + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q[0] <= '0;
      ptr_q[1] <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-modify-write. The memory is read combinationally and written on the
  // commit edge, so a row to the same slot on the next cycle already sees it.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]            mem_q [2][DEPTH][COLS];
  logic [COLS-1:0][ACC_W-1:0]  row_d;
  logic [COLS-1:0]             ovf;

  always_comb begin
    logic [ACC_W-1:0] old_v;
    logic [ACC_W:0]   sum_v;
    old_v = '0;
    sum_v = '0;
    row_d = '0;
    ovf   = '0;
    for (int c = 0; c < COLS; c++) begin
      old_v = row_mode ? mem_q[row_buf][slot_ptr][c] : '0;
      // One guard bit: overflow is visible as disagreement of the top two bits.
      sum_v = {old_v[ACC_W-1], old_v}
            + {{(ACC_W + 1 - IN_W){aligned[c][IN_W-1]}}, aligned[c]};
      ovf[c] = sum_v[ACC_W] ^ sum_v[ACC_W-1];
      if ((SATURATE != 0) && ovf[c]) begin
        row_d[c] = sum_v[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        row_d[c] = sum_v[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < DEPTH; s++)
          for (int c = 0; c < COLS; c++)
            mem_q[b][s][c] <= '0;
    end else if (wr_en) begin
      for (int c = 0; c < COLS; c++) mem_q[row_buf][slot_ptr][c] <= row_d[c];
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO.
  // ---------------------------------------------------------------------------
  logic [COLS*ACC_W-1:0] fifo_data_q [OUT_DEPTH];
  logic                  fifo_buf_q  [OUT_DEPTH];
  logic [RW-1:0]         fifo_row_q  [OUT_DEPTH];
  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  full, pop, push_ok, drop;

  always_comb begin
    full    = (cnt_q == CW'(OUT_DEPTH));
    pop     = (cnt_q != '0) && out_ready;
    // When full, a simultaneous pop frees the slot being written.
    push_ok = wr_en && (!full || pop);
    drop    = wr_en && full && !pop;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    if (clear) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wp_d = (wp_q == PW'(OUT_DEPTH - 1)) ? '0 : wp_q + PW'(1);
      if (pop)     rp_d = (rp_q == PW'(OUT_DEPTH - 1)) ? '0 : rp_q + PW'(1);
      if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_buf_q[i]  <= 1'b0;
        fifo_row_q[i]  <= '0;
      end
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (push_ok) begin
        fifo_data_q[wp_q] <= row_d;
        fifo_buf_q[wp_q]  <= row_buf;
        fifo_row_q[wp_q]  <= slot_ptr;
      end
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = fifo_data_q[rp_q];
  assign out_buf   = fifo_buf_q[rp_q];
  assign out_row   = fifo_row_q[rp_q];

  // ---------------------------------------------------------------------------
  // Sticky flags.
  // ---------------------------------------------------------------------------
  logic sat_q, sat_d, drop_q, drop_d;

  always_comb begin
    sat_d  = sat_q  | (wr_en && (|ovf));
    drop_d = drop_q | drop;
    if (clear) begin
      sat_d  = 1'b0;
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      sat_q  <= sat_d;
      drop_q <= drop_d;
    end
  end

  assign sat_flag  = sat_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_accumulator_array.sv
module tb_accumulator_array;

  logic        clk, reset, clear, valid_in, acc_mode, buf_sel, out_ready;
  logic [63:0] mmu_in;

  logic         m_valid, m_buf, m_sat, m_drop;
  logic [127:0] m_data;
  logic [1:0]   m_row;
  logic         s_valid, s_buf, s_sat, s_drop;
  logic [67:0]  s_data;
  logic [0:0]   s_row;
  logic         w_valid, w_buf, w_sat, w_drop;
  logic [67:0]  w_data;
  logic [0:0]   w_row;

  accumulator_array u_main (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in),
    .acc_mode(acc_mode), .buf_sel(buf_sel), .mmu_in(mmu_in), .out_ready(out_ready),
    .out_valid(m_valid), .out_data(m_data), .out_buf(m_buf), .out_row(m_row),
    .sat_flag(m_sat), .drop_flag(m_drop)
  );

  accumulator_array #(.ACC_W(17), .DEPTH(1), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in),
    .acc_mode(acc_mode), .buf_sel(buf_sel), .mmu_in(mmu_in), .out_ready(out_ready),
    .out_valid(s_valid), .out_data(s_data), .out_buf(s_buf), .out_row(s_row),
    .sat_flag(s_sat), .drop_flag(s_drop)
  );

  accumulator_array #(.ACC_W(17), .DEPTH(1), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in),
    .acc_mode(acc_mode), .buf_sel(buf_sel), .mmu_in(mmu_in), .out_ready(out_ready),
    .out_valid(w_valid), .out_data(w_data), .out_buf(w_buf), .out_row(w_row),
    .sat_flag(w_sat), .drop_flag(w_drop)
  );

  typedef struct packed {
    logic              mode;
    logic              bsel;
    logic [3:0][15:0]  col;
    logic [3:0][31:0]  exp;
    logic              exp_buf;
    logic [1:0]        exp_row;
  } vec_t;

  vec_t vecs [25];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issue_cyc = 0;
  int   first_valid_cyc = -1;

  logic [130:0] mq [$];
  logic [69:0]  sq [$];
  logic [69:0]  wq [$];

  int sat_exp  [5][4] = '{'{1,2,3,4}, '{2,4,6,8}, '{32767,32767,-32768,5},
                          '{65534,65534,-65536,10}, '{65535,65535,-65536,15}};
  int wrap_exp [5][4] = '{'{1,2,3,4}, '{2,4,6,8}, '{32767,32767,-32768,5},
                          '{65534,65534,-65536,10}, '{-32771,-32771,32768,15}};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid && out_ready) begin
      mq.push_back({m_buf, m_row, m_data});
      $display("pop main buf=%0d row=%0d data=%h", m_buf, m_row, m_data);
    end
    if (s_valid && out_ready) sq.push_back({s_buf, s_row, s_data});
    if (w_valid && out_ready) wq.push_back({w_buf, w_row, w_data});
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic m, input logic b,
                              input int c0, input int c1, input int c2, input int c3,
                              input int e0, input int e1, input int e2, input int e3,
                              input logic eb, input int er);
    vec_t v;
    v.mode = m;
    v.bsel = b;
    v.col[0] = 16'(c0); v.col[1] = 16'(c1); v.col[2] = 16'(c2); v.col[3] = 16'(c3);
    v.exp[0] = 32'(e0); v.exp[1] = 32'(e1); v.exp[2] = 32'(e2); v.exp[3] = 32'(e3);
    v.exp_buf = eb;
    v.exp_row = 2'(er);
    return v;
  endfunction

  function automatic logic [67:0] pack17(input int r, input bit wrap);
    logic [67:0] p;
    for (int c = 0; c < 4; c++) p[c*17 +: 17] = wrap ? 17'(wrap_exp[r][c]) : 17'(sat_exp[r][c]);
    return p;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; valid_in = 1'b0; acc_mode = 1'b0; buf_sel = 1'b0;
    mmu_in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    mq.delete(); sq.delete(); wq.delete();
    first_valid_cyc = -1;
  endtask

  // Drive vecs[first .. first+n-1] back to back with the MMU column skew.
  task automatic send(input int first, input int n);
    for (int t = 0; t < n + 3; t++) begin
      valid_in = (t < n);
      if (t < n) begin
        acc_mode = vecs[first+t].mode;
        buf_sel  = vecs[first+t].bsel;
      end
      mmu_in = '0;
      for (int c = 0; c < 4; c++) begin
        if (t - c >= 0 && t - c < n) mmu_in[c*16 +: 16] = vecs[first+t-c].col[c];
      end
      tick();
      if (t == 0) issue_cyc = cyc;
    end
    valid_in = 1'b0;
    mmu_in = '0;
  endtask

  task automatic wait_q(input int n);
    for (int i = 0; i < 60 && mq.size() < n; i++) tick();
    repeat (3) tick();
    chk("main pop count", 128'(mq.size()), 128'(n));
  endtask

  task automatic chk_main(input int qi, input int vi);
    logic [130:0] e;
    if (qi >= mq.size()) begin
      checks++;
      errors++;
      $display("FAIL main entry %0d: got missing required vector %0d", qi, vi);
    end else begin
      e = mq[qi];
      chk($sformatf("main%0d data", vi), e[127:0], vecs[vi].exp);
      chk($sformatf("main%0d buf", vi), 128'(e[130]), 128'(vecs[vi].exp_buf));
      chk($sformatf("main%0d row", vi), 128'(e[129:128]), 128'(vecs[vi].exp_row));
    end
  endtask

  task automatic chk_narrow(input string name, input int qi, input logic [69:0] exp, input bit wrap);
    if (qi >= (wrap ? wq.size() : sq.size())) begin
      checks++;
      errors++;
      $display("FAIL %s: got missing entry required %h", name, exp);
    end else begin
      chk(name, wrap ? 128'(wq[qi]) : 128'(sq[qi]), 128'(exp));
    end
  endtask

  initial begin
    // inputs                                expected
    vecs[0]  = mk(0,0,   1,  2,  3,  4,      1,  2,  3,  4, 0,0);
    vecs[1]  = mk(0,1,  10, 20, 30, 40,     10, 20, 30, 40, 1,0);
    vecs[2]  = mk(0,1,  -5,  6, -7,  8,     -5,  6, -7,  8, 1,1);
    vecs[3]  = mk(1,1, 100,200,300,400,    100,200,300,400, 1,2);
    vecs[4]  = mk(0,1,   7,  7,  7,  7,      7,  7,  7,  7, 1,3);
    vecs[5]  = mk(1,1,   1,  1,  1,  1,     11, 21, 31, 41, 1,0);
    vecs[6]  = mk(1,0,   1,  1,  1,  1,      1,  1,  1,  1, 0,1);
    vecs[7]  = mk(0,0,   1,  2,  3,  4,      0,  0,  0,  0, 0,0);
    vecs[8]  = mk(1,0,   1,  2,  3,  4,      0,  0,  0,  0, 0,0);
    vecs[9]  = mk(0,0, 32767,32767,-32768,5, 0,0,0,0, 0,0);
    vecs[10] = mk(1,0, 32767,32767,-32768,5, 0,0,0,0, 0,0);
    vecs[11] = mk(1,0, 32767,32767,-32768,5, 0,0,0,0, 0,0);
    for (int k = 0; k < 5; k++) vecs[12+k] = mk(0,0, k+1,k+1,k+1,k+1, k+1,k+1,k+1,k+1, 0, k % 4);
    vecs[17] = mk(0,0,   5,  6,  7,  8,      5,  6,  7,  8, 0,0);
    for (int k = 0; k < 5; k++) vecs[18+k] = mk(0,1, k+1,k+1,k+1,k+1, 0,0,0,0, 1,0);
    vecs[23] = mk(1,0,   0,  0,  0,  0,      5,  6,  7,  8, 0,0);
    vecs[24] = mk(1,1,   0,  0,  0,  0,      5,  5,  5,  5, 1,0);

    out_ready = 1'b0;
    do_reset();

    // Reset state
    chk("reset out_valid", 128'(m_valid), 128'(0));
    chk("reset out_data", m_data, 128'(0));
    chk("reset out_buf", 128'(m_buf), 128'(0));
    chk("reset out_row", 128'(m_row), 128'(0));
    chk("reset sat_flag", 128'(m_sat), 128'(0));
    chk("reset drop_flag", 128'(m_drop), 128'(0));

    // Latency, back-to-back rows, pointer wrap, buffer independence
    out_ready = 1'b1;
    send(0, 7);
    wait_q(7);
    chk("latency", 128'(first_valid_cyc - issue_cyc), 128'(4));
    for (int i = 0; i < 7; i++) chk_main(i, i);
    chk("stream drop_flag", 128'(m_drop), 128'(0));
    chk("stream sat_flag", 128'(m_sat), 128'(0));

    // DEPTH=1 back-to-back accumulation, saturation and wrap
    do_reset();
    send(7, 4);
    repeat (6) tick();
    chk("sat flag before overflow", 128'(s_sat), 128'(0));
    chk("wrap flag before overflow", 128'(w_sat), 128'(0));
    send(11, 1);
    repeat (6) tick();
    chk("sat flag after overflow", 128'(s_sat), 128'(1));
    chk("wrap flag after overflow", 128'(w_sat), 128'(1));
    chk("sat drop_flag", 128'(s_drop), 128'(0));
    for (int i = 0; i < 5; i++) begin
      chk_narrow($sformatf("sat row%0d", i), i, {2'b00, pack17(i, 1'b0)}, 1'b0);
      chk_narrow($sformatf("wrap row%0d", i), i, {2'b00, pack17(i, 1'b1)}, 1'b1);
    end

    // FIFO overflow with the consumer stalled, then drain
    do_reset();
    out_ready = 1'b0;
    send(12, 5);
    repeat (4) tick();
    chk("stall out_valid", 128'(m_valid), 128'(1));
    chk("stall drop_flag", 128'(m_drop), 128'(1));
    chk("stall head data", m_data, vecs[12].exp);
    repeat (3) tick();
    chk("stall head held", m_data, vecs[12].exp);
    chk("stall head row", 128'(m_row), 128'(0));
    out_ready = 1'b1;
    wait_q(4);
    for (int i = 0; i < 4; i++) chk_main(i, 12 + i);

    // clear: in-flight row discarded, FIFO emptied, pointers and flags reset
    do_reset();
    out_ready = 1'b1;
    send(17, 1);
    wait_q(1);
    chk_main(0, 17);
    out_ready = 1'b0;
    send(18, 5);
    repeat (4) tick();
    chk("pre-clear drop_flag", 128'(m_drop), 128'(1));
    valid_in = 1'b1; acc_mode = 1'b0; buf_sel = 1'b0;
    mmu_in = '0; mmu_in[15:0] = 16'd9;
    tick();
    valid_in = 1'b0; mmu_in = '0; mmu_in[31:16] = 16'd9;
    tick();
    mmu_in = '0; mmu_in[47:32] = 16'd9; clear = 1'b1;
    tick();
    clear = 1'b0; mmu_in = '0; mmu_in[63:48] = 16'd9;
    tick();
    mmu_in = '0;
    repeat (6) tick();
    chk("post-clear out_valid", 128'(m_valid), 128'(0));
    chk("post-clear drop_flag", 128'(m_drop), 128'(0));
    chk("post-clear sat_flag", 128'(m_sat), 128'(0));
    out_ready = 1'b1;
    send(23, 2);
    wait_q(3);
    chk_main(1, 23);
    chk_main(2, 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
